// File: rtl/regfile_scoreboard.sv
// Issue-stage hazard scoreboard for the 32x32 register file: tracks pending
// writes per register and gates issue on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rj,
    input  logic             issue_rj_used,
    input  logic [4:0]       issue_rk,
    input  logic             issue_rk_used,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_we,
    input  logic             issue_var,
    input  logic [LAT_W-1:0] issue_lat,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [31:0]      stall_cnt
);

    logic [LAT_W-1:0] cnt_q [32];
    logic [31:0]      var_q;
    logic [31:0]      beff;
    logic             hazard;
    logic             fire;
    logic             set_en;
    logic [LAT_W-1:0] lat_eff;

    // cnt==1 and a same-cycle matching writeback both count as free,
    // because the register file forwards the write to the readers.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        beff = '0;
        for (int r = 1; r < 32; r++) begin
            beff[r] = (cnt_q[r] > LAT_W'(1)) |
                      (var_q[r] & ~(wb_valid && (wb_rd == 5'(r))));
        end
    end

    assign hazard      = (issue_rj_used & beff[issue_rj]) |
                         (issue_rk_used & beff[issue_rk]) |
                         (issue_rd_we   & beff[issue_rd]);
    assign issue_ready = ~hazard & ~flush;
    assign fire        = issue_valid & issue_ready;
    assign set_en      = fire & issue_rd_we & (issue_rd != 5'd0);
    assign lat_eff     = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

    // Issue set has priority over the countdown and the writeback clear.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 32; r++) begin
            if (rst || flush || r == 0) begin
                cnt_q[r] <= '0;
                var_q[r] <= 1'b0;
            end else if (set_en && (issue_rd == 5'(r))) begin
                cnt_q[r] <= issue_var ? '0 : lat_eff;
                var_q[r] <= issue_var;
            end else begin
                if (cnt_q[r] != '0)
                    cnt_q[r] <= cnt_q[r] - LAT_W'(1);
                if (wb_valid && (wb_rd == 5'(r)))
                    var_q[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < 32; r++)
            busy_vec[r] = (cnt_q[r] != '0) | var_q[r];
    end

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (issue_valid && !issue_ready && !flush && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rj;
    logic        issue_rj_used;
    logic [4:0]  issue_rk;
    logic        issue_rk_used;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_var;
    logic [2:0]  issue_lat;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_vec;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard #(.LAT_W(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rj(issue_rj), .issue_rj_used(issue_rj_used),
        .issue_rk(issue_rk), .issue_rk_used(issue_rk_used),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_var(issue_var), .issue_lat(issue_lat), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        issue_valid = 0; issue_rj = 0; issue_rj_used = 0; issue_rk = 0; issue_rk_used = 0;
        issue_rd = 0; issue_rd_we = 0; issue_var = 0; issue_lat = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    // Advance one edge; inputs are changed 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writer(input logic [4:0] rd, input logic v, input logic [2:0] lat);
        idle();
        issue_valid = 1; issue_rd = rd; issue_rd_we = 1; issue_var = v; issue_lat = lat;
    endtask

    task automatic reader(input logic [4:0] rj, input logic rj_u, input logic [4:0] rk, input logic rk_u);
        idle();
        issue_valid = 1; issue_rj = rj; issue_rj_used = rj_u; issue_rk = rk; issue_rk_used = rk_u;
    endtask

    task automatic chk_ready(input string name, input logic exp);
        #1;
        n_cmp++;
        if (issue_ready !== exp) begin
            n_err++;
            $display("FAIL %s: issue_ready got %b want %b", name, issue_ready, exp);
        end
    endtask

    task automatic chk_busy(input string name, input logic [31:0] exp);
        n_cmp++;
        if (busy_vec !== exp) begin
            n_err++;
            $display("FAIL %s: busy_vec got %h want %h", name, busy_vec, exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic [31:0] exp);
        n_cmp++;
        if (stall_cnt !== exp) begin
            n_err++;
            $display("FAIL %s: stall_cnt got %0d want %0d", name, stall_cnt, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        chk_busy("reset_busy", 32'h0);
        chk_stall("reset_stall", 32'd0);
        chk_ready("reset_ready", 1'b1);
    endtask

    task automatic test_fixed();
        writer(5'd5, 1'b0, 3'd3);
        chk_ready("fixed_issue", 1'b1);
        step();
        reader(5'd5, 1'b1, 5'd0, 1'b0);
        chk_ready("fixed_t1", 1'b0);
        chk_busy("fixed_busy_t1", 32'h20);
        step();
        chk_ready("fixed_t2", 1'b0);
        chk_busy("fixed_busy_t2", 32'h20);
        step();
        chk_ready("fixed_t3", 1'b1);
        chk_busy("fixed_busy_t3", 32'h20);
        step();
        idle();
        chk_busy("fixed_busy_t4", 32'h0);
        chk_stall("fixed_stall", 32'd2);
    endtask

    task automatic test_variable();
        writer(5'd7, 1'b1, 3'd0);
        chk_ready("var_issue", 1'b1);
        step();
        for (int i = 1; i < 10; i++) begin
            reader(5'd0, 1'b0, 5'd7, 1'b1);
            chk_ready($sformatf("var_wait_%0d", i), 1'b0);
            step();
        end
        reader(5'd0, 1'b0, 5'd7, 1'b1);
        wb_valid = 1; wb_rd = 5'd7;
        chk_ready("var_bypass", 1'b1);
        step();
        idle();
        chk_busy("var_busy_after_wb", 32'h0);
        chk_stall("var_stall", 32'd11);
    endtask

    task automatic test_waw_r0();
        writer(5'd9, 1'b1, 3'd0);
        chk_ready("waw_first", 1'b1);
        step();
        writer(5'd9, 1'b0, 3'd2);
        chk_ready("waw_hazard", 1'b0);
        step();
        writer(5'd0, 1'b1, 3'd0);
        chk_ready("r0_writer", 1'b1);
        step();
        idle();
        chk_busy("r0_not_busy", 32'h200);
        chk_stall("waw_stall", 32'd12);
    endtask

    task automatic test_simultaneous();
        writer(5'd9, 1'b0, 3'd2);
        wb_valid = 1; wb_rd = 5'd9;
        chk_ready("simul_issue", 1'b1);
        step();
        reader(5'd9, 1'b1, 5'd0, 1'b0);
        chk_busy("simul_busy", 32'h200);
        chk_ready("simul_cnt2", 1'b0);
        step();
        chk_ready("simul_cnt1_var0", 1'b1);
        step();
        idle();
        chk_busy("simul_clear", 32'h0);
    endtask

    task automatic test_flush();
        writer(5'd3, 1'b1, 3'd0);
        step();
        writer(5'd4, 1'b0, 3'd5);
        step();
        chk_busy("flush_pre", 32'h18);
        writer(5'd6, 1'b0, 3'd1);
        flush = 1;
        chk_ready("flush_blocks", 1'b0);
        step();
        chk_busy("flush_post", 32'h0);
        reader(5'd3, 1'b1, 5'd4, 1'b1);
        chk_ready("flush_reader", 1'b1);
        step();
        idle();
        chk_busy("flush_r6_not_set", 32'h0);
        chk_stall("flush_stall", 32'd13);
    endtask

    task automatic test_back_to_back();
        writer(5'd1, 1'b0, 3'd1);
        chk_ready("b2b_c0", 1'b1);
        step();
        writer(5'd2, 1'b0, 3'd0);
        issue_rj = 5'd1; issue_rj_used = 1;
        chk_ready("b2b_c1", 1'b1);
        step();
        chk_busy("b2b_lat0_as1", 32'h4);
        writer(5'd3, 1'b0, 3'd1);
        issue_rj = 5'd2; issue_rj_used = 1;
        chk_ready("b2b_c2", 1'b1);
        step();
        reader(5'd3, 1'b1, 5'd0, 1'b0);
        chk_ready("b2b_c3", 1'b1);
        step();
        idle();
        chk_stall("b2b_stall", 32'd13);
    endtask

    task automatic test_reset_mid();
        writer(5'd8, 1'b1, 3'd0);
        step();
        reader(5'd8, 1'b1, 5'd0, 1'b0);
        step();
        idle();
        chk_busy("mid_pending", 32'h100);
        rst = 1;
        step();
        rst = 0;
        chk_busy("mid_reset_busy", 32'h0);
        chk_stall("mid_reset_stall", 32'd0);
        chk_ready("mid_reset_ready", 1'b1);
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_fixed();
        test_variable();
        test_waw_r0();
        test_simultaneous();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Issue-stage hazard controller for the 32x32 register file (2 read ports rj/rk, 1 write port rd, write-through forwarding inside the register file). It tracks pending writes per architectural register and gates instruction issue on RAW/WAW hazards. Fixed-latency ops (ALU, MUL) clear themselves by countdown; variable-latency ops (LD, DIV, CSR) clear on writeback. It sits between the decode/issue stage and the execute pipes, and feeds a stall performance counter.

Parameters:
LAT_W, 3, width of the latency field and of the per-register countdown; maximum fixed latency is 2**LAT_W-1 (7 by default).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_rj  in  5  source register 1 index
issue_rj_used  in  1  instruction reads rj
issue_rk  in  5  source register 2 index
issue_rk_used  in  1  instruction reads rk
issue_rd  in  5  destination index
issue_rd_we  in  1  instruction writes rd
issue_var  in  1  1 = variable latency (cleared by wb), 0 = fixed
issue_lat  in  LAT_W  fixed latency in cycles; used only when issue_var=0
issue_ready  out  1  no hazard, issue accepted this cycle if issue_valid
wb_valid  in  1  variable-latency writeback to the register file this cycle
wb_rd  in  5  writeback destination
flush  in  1  pipeline flush; kill all pending state
busy_vec  out  32  registered per-register pending flag (cnt!=0 | var)
stall_cnt  out  32  cycles with issue_valid & ~issue_ready & ~flush

Behaviour:
- State per register r (1..31): cnt[r] (LAT_W bits), var[r] (1 bit). r0 has no state; it is never busy, and writes to r0 set nothing.
- Effective busy (comb): beff[r] = (cnt[r] > 1) | (var[r] & ~(wb_valid & wb_rd==r)). cnt==1 and a matching wb both count as free, because the register file forwards a same-cycle write.
- hazard = (rj_used & beff[rj]) | (rk_used & beff[rk]) | (rd_we & beff[rd]).
- issue_ready = ~hazard & ~flush (combinational; independent of issue_valid). fire = issue_valid & issue_ready.
- Every cycle: each nonzero cnt decrements by 1. On wb_valid, var[wb_rd] clears; a wb to a non-pending register or to r0 is ignored.
- On fire with rd_we and rd!=0:
  - if issue_var=1: var[rd]<=1 and cnt[rd]<=0;
  - else cnt[rd]<=max(issue_lat,1) and var[rd]<=0.
  - Issue set wins over a same-cycle decrement or wb clear on the same register.
- Fixed-latency timing: a writer fired at cycle T with latency L lets a dependent instruction fire at cycle T+L. With L=1, a dependent instruction fires at T+1.
- Variable-latency timing: a dependent instruction fires in the same cycle as the matching wb.
- flush: all cnt and var clear at the next edge. Any issue in the flush cycle is not accepted. wb in the flush cycle is irrelevant.
- stall_cnt increments by 1 per stall cycle and saturates at 0xFFFF_FFFF. It is not cleared by flush.
- busy_vec is a direct view of state (not beff). Bit 0 is always 0.
- Reset: all cnt/var = 0, busy_vec = 0, stall_cnt = 0. issue_ready = 1 after reset when flush=0. Reset asserted mid-operation discards all pending entries at the next edge. Reset has priority over flush and fire.

Test Plan:
- After reset, fixed op rd=5, L=3 at T; at T+1 rj=5 used -> ready=0 at T+1 and T+2, ready=1 at T+3; stall_cnt=2; busy_vec[5]=1 during T+1..T+3, 0 at T+4.
- Variable op rd=7 at T; a reader of rk=7 stalls until wb_valid, wb_rd=7 at T+10 -> ready=1 in cycle T+10 (bypass), busy_vec[7]=0 at T+11.
- WAW and r0: var op rd=9 pending; new writer rd=9 (rj/rk unused) -> ready=0. A writer with rd=0 -> ready=1 and busy_vec stays 0.
- Simultaneous events: in the same cycle as wb_rd=9, fire a fixed L=2 writer to rd=9 -> ready=1; next cycle cnt[9]=2, var[9]=0, busy_vec[9]=1.
- Flush with regs 3 (var), 4 (cnt=5) pending plus a valid, hazard-free issue to rd=6 -> ready=0 that cycle; next cycle busy_vec=0 and a reader of r3/r4 is ready=1.
- L=1 back-to-back chain r1->r2->r3 over 3 consecutive cycles -> ready=1 every cycle, stall_cnt=0. issue_lat=0 behaves as 1.
